// File: rtl/fft8_pkg.sv
// Shared constants for the 8-point FFT datapath: frame geometry, counter
// widths, twiddle factors and the frame-hold state encoding.
package fft8_pkg;

  localparam int unsigned FRAME_LEN   = 8;
  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned SLOT_W      = $clog2(FRAME_LEN);
  localparam int unsigned FILL_CNT_W  = $clog2(FRAME_LEN + 1);

  // W8^k twiddles, Q1.7 in 9-bit two's complement (cos/sin of k*45 degrees)
  localparam int unsigned TW_W = 9;
  localparam logic signed [TW_W-1:0] TW_ONE    = 9'sd128;
  localparam logic signed [TW_W-1:0] TW_COS_45 = 9'sd91;
  localparam logic signed [TW_W-1:0] TW_ZERO   = 9'sd0;

  typedef enum logic {
    HOLD_IDLE = 1'b0,
    HOLD_BUSY = 1'b1
  } hold_state_e;

endpackage

// File: rtl/fft8_input_loader_frame_hold_ctrl.sv
// Hold-bank controller: decides when the full fill bank moves into the hold
// bank and tracks whether the held frame is still owned by the FFT.
module frame_hold_ctrl
  import fft8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic fill_full,
  input  logic fft_done,
  output logic load,
  output logic frame_valid,
  output logic frame_start
);

  hold_state_e state_q;

  // Load when the hold bank is free or is being released on this very edge.
  assign load = fill_full && ((state_q == HOLD_IDLE) || fft_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HOLD_IDLE;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        state_q     <= HOLD_BUSY;
        frame_valid <= 1'b1;
      end else if ((state_q == HOLD_BUSY) && fft_done) begin
        state_q     <= HOLD_IDLE;
        frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fft8_input_loader.sv
// Serial-to-parallel frame loader for the 8-point FFT: fills one bank from a
// valid/ready sample stream while a second bank holds the frame under transform.
module fft8_input_loader
  import fft8_pkg::*;
#(
  parameter int unsigned width = 9
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [width-1:0]       s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic [width-1:0]       x0,
  output logic [width-1:0]       x1,
  output logic [width-1:0]       x2,
  output logic [width-1:0]       x3,
  output logic [width-1:0]       x4,
  output logic [width-1:0]       x5,
  output logic [width-1:0]       x6,
  output logic [width-1:0]       x7,
  output logic                   frame_valid,
  output logic                   frame_start,
  input  logic                   fft_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  logic [FILL_CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [width-1:0]       fill_q [FRAME_LEN];
  logic [width-1:0]       hold_q [FRAME_LEN];
  logic                   fill_full;
  logic                   load;
  logic                   accept;

  assign fill_full = (fill_cnt_q == FILL_CNT_W'(FRAME_LEN));
  assign s_ready   = (fill_cnt_q <  FILL_CNT_W'(FRAME_LEN));
  assign accept    = s_valid && s_ready;

  frame_hold_ctrl u_hold_ctrl (
    .clk         (clk),
    .rst         (rst),
    .fill_full   (fill_full),
    .fft_done    (fft_done),
    .load        (load),
    .frame_valid (frame_valid),
    .frame_start (frame_start)
  );

  // A load only happens with the fill bank full, so it never races an accept.
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    frame_cnt_d = frame_cnt_q;
    if (load) begin
      fill_cnt_d  = '0;
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end else if (accept) begin
      fill_cnt_d  = fill_cnt_q + FILL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_cnt_q  <= '0;
      frame_cnt_q <= '0;
      for (int unsigned i = 0; i < FRAME_LEN; i++) begin
        fill_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (accept) begin
        fill_q[fill_cnt_q[SLOT_W-1:0]] <= s_data;
      end
      if (load) begin
        hold_q <= fill_q;
      end
    end
  end

  assign x0        = hold_q[0];
  assign x1        = hold_q[1];
  assign x2        = hold_q[2];
  assign x3        = hold_q[3];
  assign x4        = hold_q[4];
  assign x5        = hold_q[5];
  assign x6        = hold_q[6];
  assign x7        = hold_q[7];
  assign frame_cnt = frame_cnt_q;

endmodule
